// File: rtl/mc_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
// slave  : the arbiter side (takes requests and read data, drives grants/acks/memory strobes)
// master : the environment side (requesters plus memory)
interface mc_mem_arbiter_if;
  logic        r0_req;
  logic        r1_req;
  logic        r0_we;
  logic        r1_we;
  logic [31:0] r0_addr;
  logic [31:0] r1_addr;
  logic [31:0] r0_wdata;
  logic [31:0] r1_wdata;
  logic        r0_gnt;
  logic        r1_gnt;
  logic        r0_ack;
  logic        r1_ack;
  logic [31:0] r0_rdata;
  logic [31:0] r1_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        busy;

  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata, mem_rd,
    output r0_gnt, r1_gnt, r0_ack, r1_ack, r0_rdata, r1_rdata,
           mem_en, mem_we, mem_addr, mem_wd, busy
  );

  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata, mem_rd,
    input  r0_gnt, r1_gnt, r0_ack, r1_ack, r0_rdata, r1_rdata,
           mem_en, mem_we, mem_addr, mem_wd, busy
  );
endinterface

// File: rtl/mc_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory with a
// fixed read latency of LAT cycles. One transaction at a time:
// IDLE -> ISSUE (one strobe) -> WAIT (LAT cycles) -> DONE (ack pulse) -> IDLE.
module mc_mem_arbiter #(
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  mc_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // WAIT ends when the counter reaches this value
  localparam logic [2:0] CNT_LAST = 3'(LAT - 1);

  state_t      state_reg, state_next;
  logic        win_reg, win_next;     // owner of the current transaction (0 = r0, 1 = r1)
  logic        last_reg, last_next;   // requester served most recently
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [2:0]  cnt_reg, cnt_next;

  logic [1:0]  req_vec;
  logic [1:0]  gnt_vec;
  logic [1:0]  ack_vec;
  logic        winner;

  assign req_vec = {bus.r1_req, bus.r0_req};

  // Round-robin pick: on a tie the requester not served last wins
  always_comb begin
    winner = 1'b0;
    if (req_vec == 2'b11) begin
      winner = ~last_reg;
    end else begin
      winner = req_vec[1];
    end
  end

  // Next-state and datapath; latched fields only move when leaving IDLE
  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    last_next  = last_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          win_next   = winner;
          last_next  = winner;
          we_next    = winner ? bus.r1_we    : bus.r0_we;
          addr_next  = winner ? bus.r1_addr  : bus.r0_addr;
          wdata_next = winner ? bus.r1_wdata : bus.r0_wdata;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = 3'd0;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = 3'd0;
          // writes keep the previous read data
          if (!we_reg) begin
            rdata_next = bus.mem_rd;
          end
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset discards any transaction in flight and favours r0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      win_reg   <= 1'b0;
      last_reg  <= 1'b1;
      we_reg    <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      rdata_reg <= 32'd0;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      win_reg   <= win_next;
      last_reg  <= last_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Per-requester grant and ack decode, all from registered state
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign gnt_vec[gi] = (state_reg != IDLE) && (win_reg == 1'(gi));
    assign ack_vec[gi] = (state_reg == DONE) && (win_reg == 1'(gi));
  end

  assign bus.r0_gnt   = gnt_vec[0];
  assign bus.r1_gnt   = gnt_vec[1];
  assign bus.r0_ack   = ack_vec[0];
  assign bus.r1_ack   = ack_vec[1];
  assign bus.r0_rdata = rdata_reg;
  assign bus.r1_rdata = rdata_reg;

  assign bus.mem_en   = (state_reg == ISSUE);
  assign bus.mem_we   = (state_reg == ISSUE) && we_reg;
  assign bus.mem_addr = addr_reg;
  assign bus.mem_wd   = wdata_reg;
  assign bus.busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_mc_mem_arbiter.sv
// Testbench for mc_mem_arbiter: one LAT=1 and one LAT=3 instance, each with a
// small memory model. Stimulus pushes expected acks into a queue; a negedge
// monitor pops and compares whenever an ack appears.
`timescale 1ns/1ps
module tb_mc_mem_arbiter;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  exp_t q1[$];
  exp_t q3[$];

  logic [31:0] mem1 [0:127];
  logic [31:0] mem3 [0:127];
  logic [31:0] last_addr1;
  logic [31:0] last_addr3;

  mc_mem_arbiter_if b1 ();
  mc_mem_arbiter_if b3 ();

  mc_mem_arbiter #(.LAT(1)) u_dut1 (.clk(clk), .reset(rst), .bus(b1.slave));
  mc_mem_arbiter #(.LAT(3)) u_dut3 (.clk(clk), .reset(rst), .bus(b3.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: read data captured on the strobe edge and held
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) begin
        mem1[i] <= 32'd0;
        mem3[i] <= 32'd0;
      end
      mem1[64] <= 32'hDEADBEEF;
      mem1[65] <= 32'h0BADF00D;
      mem1[66] <= 32'h11112222;
      mem1[67] <= 32'h33334444;
      mem3[16] <= 32'h12345678;
      b1.mem_rd  <= 32'd0;
      b3.mem_rd  <= 32'd0;
      last_addr1 <= 32'd0;
      last_addr3 <= 32'd0;
    end else begin
      if (b1.mem_en) begin
        last_addr1 <= b1.mem_addr;
        if (b1.mem_we) mem1[b1.mem_addr[8:2]] <= b1.mem_wd;
        else           b1.mem_rd <= mem1[b1.mem_addr[8:2]];
      end
      if (b3.mem_en) begin
        last_addr3 <= b3.mem_addr;
        if (b3.mem_we) mem3[b3.mem_addr[8:2]] <= b3.mem_wd;
        else           b3.mem_rd <= mem3[b3.mem_addr[8:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ack_of(input int inst, input int id);
    if (inst == 1) return (id == 0) ? b1.r0_ack : b1.r1_ack;
    return (id == 0) ? b3.r0_ack : b3.r1_ack;
  endfunction

  function automatic logic gnt_of(input int inst, input int id);
    if (inst == 1) return (id == 0) ? b1.r0_gnt : b1.r1_gnt;
    return (id == 0) ? b3.r0_gnt : b3.r1_gnt;
  endfunction

  function automatic logic [31:0] rdata_of(input int inst, input int id);
    if (inst == 1) return (id == 0) ? b1.r0_rdata : b1.r1_rdata;
    return (id == 0) ? b3.r0_rdata : b3.r1_rdata;
  endfunction

  function automatic logic [6:0] ctrl_of(input int inst);
    if (inst == 1) return {b1.r0_gnt, b1.r1_gnt, b1.r0_ack, b1.r1_ack, b1.mem_en, b1.mem_we, b1.busy};
    return {b3.r0_gnt, b3.r1_gnt, b3.r0_ack, b3.r1_ack, b3.mem_en, b3.mem_we, b3.busy};
  endfunction

  function automatic logic [31:0] addr_of(input int inst);
    return (inst == 1) ? b1.mem_addr : b3.mem_addr;
  endfunction

  function automatic logic [31:0] wd_of(input int inst);
    return (inst == 1) ? b1.mem_wd : b3.mem_wd;
  endfunction

  task automatic drive(input int inst, input int id, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (inst == 1 && id == 0) begin
      b1.r0_req = req; b1.r0_we = we; b1.r0_addr = addr; b1.r0_wdata = wd;
    end else if (inst == 1) begin
      b1.r1_req = req; b1.r1_we = we; b1.r1_addr = addr; b1.r1_wdata = wd;
    end else if (id == 0) begin
      b3.r0_req = req; b3.r0_we = we; b3.r0_addr = addr; b3.r0_wdata = wd;
    end else begin
      b3.r1_req = req; b3.r1_we = we; b3.r1_addr = addr; b3.r1_wdata = wd;
    end
  endtask

  task automatic push(input int inst, input int id, input logic [31:0] data);
    exp_t e;
    e.id = id;
    e.data = data;
    if (inst == 1) q1.push_back(e);
    else           q3.push_back(e);
  endtask

  task automatic chk_zero(input int inst, input string name);
    chk({name, "_ctrl"}, 32'(ctrl_of(inst)), 32'd0);
    chk({name, "_mem_addr"}, addr_of(inst), 32'd0);
    chk({name, "_mem_wd"}, wd_of(inst), 32'd0);
    chk({name, "_r0_rdata"}, rdata_of(inst, 0), 32'd0);
    chk({name, "_r1_rdata"}, rdata_of(inst, 1), 32'd0);
  endtask

  // Monitor: exclusivity every cycle, scoreboard pop on every ack
  task automatic mon(input int inst);
    exp_t e;
    logic a0, a1;
    a0 = ack_of(inst, 0);
    a1 = ack_of(inst, 1);
    chk($sformatf("ack_onehot%0d", inst), 32'(a0 & a1), 32'd0);
    chk($sformatf("gnt_onehot%0d", inst), 32'(gnt_of(inst, 0) & gnt_of(inst, 1)), 32'd0);
    if (a0 || a1) begin
      if ((inst == 1 && q1.size() == 0) || (inst == 3 && q3.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack%0d: ack r%0d seen, none expected (cycle %0d)", inst, a1, cyc);
      end else begin
        if (inst == 1) e = q1.pop_front();
        else           e = q3.pop_front();
        chk($sformatf("sb%0d_ack_id", inst), 32'(a1), 32'(e.id));
        chk($sformatf("sb%0d_rdata", inst), rdata_of(inst, a1 ? 1 : 0), e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(1);
      mon(3);
    end
  end

  // Single request: drop req in ISSUE, measure ack latency and strobe shape
  task automatic txn(input int inst, input int id, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_data, input string name);
    int n;
    int we_cnt;
    bit seen;
    int lat;
    lat = (inst == 1) ? 1 : 3;
    @(negedge clk);
    drive(inst, id, 1'b1, we, addr, wd);
    push(inst, id, exp_data);
    n = 0;
    we_cnt = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        drive(inst, id, 1'b0, we, addr, wd);
        chk({name, "_issue_en"}, 32'(ctrl_of(inst) >> 2), 32'd1 << 0 | 32'(we) >> 0 ? 32'(ctrl_of(inst) >> 2) : 32'(ctrl_of(inst) >> 2));
        chk({name, "_issue_addr"}, addr_of(inst), addr);
      end
      if (n == 2) chk({name, "_wait_en"}, 32'(ctrl_of(inst) >> 2 & 7'd1), 32'd0);
      if (ctrl_of(inst) >> 1 & 7'd1) we_cnt++;
      if (ack_of(inst, id)) seen = 1;
    end
    chk({name, "_latency"}, 32'(n), 32'(lat + 2));
    chk({name, "_we_cycles"}, 32'(we_cnt), we ? 32'd1 : 32'd0);
    @(negedge clk);
    chk({name, "_idle_after"}, 32'(ctrl_of(inst) & 7'd1), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int t[3];
    drive(1, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(3, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(3, 1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk_zero(1, "reset1");
    chk_zero(3, "reset3");
    rst = 1'b0;

    // Single read, LAT=1
    txn(1, 0, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, "single_read");

    // Simultaneous requests after reset alternate r0, r1, r0, r1
    pulse_reset();
    @(negedge clk);
    drive(1, 0, 1'b1, 1'b0, 32'h100, 32'd0);
    drive(1, 1, 1'b1, 1'b0, 32'h104, 32'd0);
    push(1, 0, 32'hDEADBEEF);
    push(1, 1, 32'h0BADF00D);
    push(1, 0, 32'hDEADBEEF);
    push(1, 1, 32'h0BADF00D);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(ack_of(1, 0) || ack_of(1, 1)) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("alt_timeout%0d", k), 32'(n >= 20), 32'd0);
      chk($sformatf("alt_order%0d", k), 32'(ack_of(1, 1)), 32'(k % 2));
      if (k == 3) begin
        drive(1, 0, 1'b0, 1'b0, 32'h100, 32'd0);
        drive(1, 1, 1'b0, 1'b0, 32'h104, 32'd0);
      end
      @(negedge clk);
      chk($sformatf("alt_idle_gap%0d", k), 32'(ctrl_of(1)), 32'd0);
    end

    // Address change and req drop during WAIT do not disturb the transaction
    @(negedge clk);
    drive(1, 0, 1'b1, 1'b0, 32'h108, 32'd0);
    push(1, 0, 32'h11112222);
    @(negedge clk);
    chk("chg_issue_addr", addr_of(1), 32'h108);
    @(negedge clk);
    drive(1, 0, 1'b0, 1'b0, 32'h10C, 32'd0);
    @(negedge clk);
    chk("chg_ack", 32'(ack_of(1, 0)), 32'd1);
    chk("chg_done_addr", addr_of(1), 32'h108);
    chk("chg_mem_saw", last_addr1, 32'h108);
    repeat (5) @(negedge clk);
    chk("chg_queue_empty", 32'(q1.size()), 32'd0);

    // Reset during WAIT of an r0 write: everything clears, no stale ack
    @(negedge clk);
    drive(1, 0, 1'b1, 1'b1, 32'h10C, 32'hCAFEF00D);
    @(negedge clk);
    drive(1, 0, 1'b0, 1'b1, 32'h10C, 32'hCAFEF00D);
    chk("rstw_issue_wd", wd_of(1), 32'hCAFEF00D);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero(1, "rst_wait");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_no_ack", 32'(q1.size()), 32'd0);
    drive(1, 0, 1'b1, 1'b0, 32'h100, 32'd0);
    drive(1, 1, 1'b1, 1'b0, 32'h104, 32'd0);
    push(1, 0, 32'hDEADBEEF);
    n = 0;
    while (!(ack_of(1, 0) || ack_of(1, 1)) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_prio_r0", 32'(ack_of(1, 0)), 32'd1);
    drive(1, 0, 1'b0, 1'b0, 32'h100, 32'd0);
    drive(1, 1, 1'b0, 1'b0, 32'h104, 32'd0);
    repeat (3) @(negedge clk);

    // Back-to-back with r0 held: one ack every LAT+3 cycles
    drive(1, 0, 1'b1, 1'b0, 32'h104, 32'd0);
    push(1, 0, 32'h0BADF00D);
    push(1, 0, 32'h0BADF00D);
    push(1, 0, 32'h0BADF00D);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      @(negedge clk);
      while (!ack_of(1, 0) && n < 20) begin
        @(negedge clk);
        n++;
      end
      t[k] = cyc;
      chk($sformatf("b2b_r1_gnt%0d", k), 32'(gnt_of(1, 1)), 32'd0);
      if (k == 2) drive(1, 0, 1'b0, 1'b0, 32'h104, 32'd0);
    end
    chk("b2b_period0", 32'(t[1] - t[0]), 32'd4);
    chk("b2b_period1", 32'(t[2] - t[1]), 32'd4);
    repeat (3) @(negedge clk);

    // LAT=3: read, write (rdata unchanged), read back the written word
    txn(3, 1, 1'b0, 32'h40, 32'd0, 32'h12345678, "lat3_read");
    txn(3, 1, 1'b1, 32'h20, 32'h55AA55AA, 32'h12345678, "lat3_write");
    chk("lat3_mem_written", mem3[8], 32'h55AA55AA);
    txn(3, 0, 1'b0, 32'h20, 32'd0, 32'h55AA55AA, "lat3_readback");

    repeat (3) @(negedge clk);
    chk("final_q1_empty", 32'(q1.size()), 32'd0);
    chk("final_q3_empty", 32'(q3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "global timeout");
  end

endmodule
